// File: rtl/kbd_uart_bridge.sv
// Keystroke-to-UART bridge: edge-qualified capture into a circular FIFO, serialised
// as UART frames with configurable parity and stop bits, plus overflow accounting.
module kbd_uart_bridge #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    drop_count,
    output logic [DATA_W-1:0]             last_byte
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic parity_of(input logic [DATA_W-1:0] v);
        return (PARITY == 2) ? ^v : ~^v;
    endfunction

    state_t               state_q, state_d;
    logic [CLK_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 hist_q;
    logic                 ovf_q;
    logic [7:0]           drop_q;
    logic [DATA_W-1:0]    last_q;

    logic bit_done;
    logic pop;
    logic rise;
    logic push_ok;

    assign bit_done = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));
    assign rise     = in_valid & ~hist_q;
    // A full FIFO still accepts when the serialiser frees a slot on the same edge.
    assign push_ok  = rise && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (bit_done) state_d = S_DATA;
            S_DATA: begin
                if (bit_done && bit_idx_q == IDX_W'(DATA_W - 1))
                    state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: if (bit_done) state_d = S_STOP;
            S_STOP: begin
                if (bit_done && bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        txd     = 1'b1;
        tx_busy = (state_q != S_IDLE);
        case (state_q)
            S_START: txd = 1'b0;
            S_DATA:  txd = shift_q[0];
            S_PAR:   txd = par_q;
            default: txd = 1'b1;
        endcase
    end

    always_comb begin
        clk_cnt_d = (state_q == S_IDLE || bit_done) ? '0 : clk_cnt_q + 1'b1;
        if (state_d != state_q)
            bit_idx_d = '0;
        else if (bit_done)
            bit_idx_d = bit_idx_q + 1'b1;
        else
            bit_idx_d = bit_idx_q;

        shift_d = shift_q;
        par_d   = par_q;
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            par_d   = parity_of(mem_q[rd_ptr_q]);
        end else if (state_q == S_DATA && bit_done) begin
            shift_d = shift_q >> 1;
        end

        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + 1'b1;
        else if (!push_ok && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            hist_q    <= 1'b1;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            last_q    <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            count_q   <= count_d;
            hist_q    <= in_valid;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                last_q   <= in_data;
            end else if (rise) begin
                ovf_q  <= 1'b1;
                drop_q <= sat_inc8(drop_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        if (push_ok)
            mem_q[wr_ptr_q] <= in_data;
    end

    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign last_byte  = last_q;

endmodule

// File: tb/tb_kbd_uart_bridge.sv
// Bench for kbd_uart_bridge: three differently configured instances share one stimulus
// stream and are compared every cycle against a queue/waveform model of the bridge.
module tb_kbd_uart_bridge;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    logic       txd0, txd1, txd2, busy0, busy1, busy2, ovf0, ovf1, ovf2;
    logic [2:0] cnt0;
    logic [3:0] cnt1;
    logic [4:0] cnt2;
    logic [7:0] drop0, drop1, drop2, last0, last1, last2;

    kbd_uart_bridge #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .txd(txd0), .tx_busy(busy0), .fifo_count(cnt0), .overflow(ovf0),
        .drop_count(drop0), .last_byte(last0));

    kbd_uart_bridge #(.DATA_W(8), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .txd(txd1), .tx_busy(busy1), .fifo_count(cnt1), .overflow(ovf1),
        .drop_count(drop1), .last_byte(last1));

    kbd_uart_bridge #(.DATA_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .txd(txd2), .tx_busy(busy2), .fifo_count(cnt2), .overflow(ovf2),
        .drop_count(drop2), .last_byte(last2));

    logic       txd_w  [3];
    logic       busy_w [3];
    logic       ovf_w  [3];
    logic [4:0] cnt_w  [3];
    logic [7:0] drop_w [3];
    logic [7:0] last_w [3];

    assign txd_w[0] = txd0;   assign txd_w[1] = txd1;   assign txd_w[2] = txd2;
    assign busy_w[0] = busy0; assign busy_w[1] = busy1; assign busy_w[2] = busy2;
    assign ovf_w[0] = ovf0;   assign ovf_w[1] = ovf1;   assign ovf_w[2] = ovf2;
    assign cnt_w[0] = {2'b00, cnt0};
    assign cnt_w[1] = {1'b0, cnt1};
    assign cnt_w[2] = cnt2;
    assign drop_w[0] = drop0; assign drop_w[1] = drop1; assign drop_w[2] = drop2;
    assign last_w[0] = last0; assign last_w[1] = last1; assign last_w[2] = last2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model: byte queue per instance, plus the expected line waveform as a frame
    // bit vector walked one clock sample at a time.
    logic [7:0]  mq     [3][16];
    int          mhead  [3];
    int          msize  [3];
    int          mpos   [3];
    int          mlen   [3];
    logic [15:0] mframe [3];
    bit          movf   [3];
    int          mdrop  [3];
    logic [7:0]  mlast  [3];
    bit          mhist;

    int cur_run [3];
    int last_run[3];
    int rises   [3];
    bit prev_busy[3];

    function automatic int dep_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 8 : 16;
    endfunction
    function automatic int par_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 0;
    endfunction
    function automatic int stp_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction
    function automatic int nbits_of(input int d);
        return 1 + 8 + ((par_of(d) != 0) ? 1 : 0) + stp_of(d);
    endfunction

    function automatic logic [15:0] frame_of(input logic [7:0] b, input int par);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (par == 2) f[9] = ^b;
        else if (par == 1) f[9] = ~^b;
        return f;
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit rise;
        rise = in_valid && !mhist;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                mhead[d] = 0; msize[d] = 0; mpos[d] = 0; mlen[d] = 0;
                movf[d] = 0; mdrop[d] = 0; mlast[d] = 8'h00;
            end
            mhist = 1;
            return;
        end
        mhist = in_valid;
        for (int d = 0; d < 3; d++) begin
            if (mpos[d] < mlen[d]) mpos[d] += 1;
            if (mpos[d] >= mlen[d] && msize[d] > 0) begin
                mframe[d] = frame_of(mq[d][mhead[d]], par_of(d));
                mlen[d]   = nbits_of(d) * CPB;
                mpos[d]   = 0;
                mhead[d]  = (mhead[d] + 1) % 16;
                msize[d] -= 1;
            end
            if (rise) begin
                if (msize[d] < dep_of(d)) begin
                    mq[d][(mhead[d] + msize[d]) % 16] = in_data;
                    msize[d] += 1;
                    mlast[d] = in_data;
                end else begin
                    movf[d] = 1;
                    if (mdrop[d] < 255) mdrop[d] += 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit  eb;
        logic et;
        for (int d = 0; d < 3; d++) begin
            eb = (mpos[d] < mlen[d]);
            et = eb ? mframe[d][mpos[d] / CPB] : 1'b1;
            check("txd", d, 32'(txd_w[d]), 32'(et));
            check("tx_busy", d, 32'(busy_w[d]), 32'(eb));
            check("fifo_count", d, 32'(cnt_w[d]), 32'(msize[d]));
            check("overflow", d, 32'(ovf_w[d]), 32'(movf[d]));
            check("drop_count", d, 32'(drop_w[d]), 32'(mdrop[d]));
            check("last_byte", d, 32'(last_w[d]), 32'(mlast[d]));
            if (busy_w[d] === 1'b1) begin
                cur_run[d] += 1;
                if (!prev_busy[d]) rises[d] += 1;
            end else if (cur_run[d] > 0) begin
                last_run[d] = cur_run[d];
                cur_run[d] = 0;
            end
            prev_busy[d] = (busy_w[d] === 1'b1);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            cur_run[d] = 0; last_run[d] = 0; rises[d] = 0; prev_busy[d] = 0;
        end
        forever begin
            @(negedge clk);
            if (chk_en) compare_all();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        in_valid = 1; in_data = b;
        step();
        in_valid = 0;
        step();
    endtask

    logic [11:0] exp_bits [3];
    int          r0 [3];
    int          p;

    initial begin
        rst = 0; in_valid = 0; in_data = 8'h00;
        repeat (3) step();
        chk_en = 1;
        for (int d = 0; d < 3; d++) begin
            check("reset_txd", d, 32'(txd_w[d]), 32'd1);
            check("reset_busy", d, 32'(busy_w[d]), 32'd0);
            check("reset_count", d, 32'(cnt_w[d]), 32'd0);
            check("reset_last", d, 32'(last_w[d]), 32'd0);
        end
        rst = 1;
        repeat (3) step();

        // Single 0x41 keystroke: LSB-first frame, parity per instance
        exp_bits[0] = 12'd3202;
        exp_bits[1] = 12'd1666;
        exp_bits[2] = 12'd642;
        in_valid = 1; in_data = 8'h41;
        step();
        in_valid = 0;
        step();
        for (int k = 0; k < 12; k++) begin
            repeat (2) @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                if (k < nbits_of(d))
                    check("frame_0x41_bit", d, 32'(txd_w[d]), 32'(exp_bits[d][k]));
            repeat (2) @(posedge clk);
        end
        repeat (10) step();
        check("frame_len", 0, 32'(last_run[0]), 32'd48);
        check("frame_len", 1, 32'(last_run[1]), 32'd44);
        check("frame_len", 2, 32'(last_run[2]), 32'd40);
        for (int d = 0; d < 3; d++) check("last_byte_0x41", d, 32'(last_w[d]), 32'h41);

        // Level held high is one keystroke
        for (int d = 0; d < 3; d++) r0[d] = rises[d];
        in_valid = 1; in_data = 8'h55;
        repeat (100) step();
        in_valid = 0;
        repeat (60) step();
        for (int d = 0; d < 3; d++) begin
            check("held_high_frames", d, 32'(rises[d] - r0[d]), 32'd1);
            check("held_high_drops", d, 32'(drop_w[d]), 32'd0);
        end

        // Two back-to-back bytes: frames contiguous, no idle gap
        for (int d = 0; d < 3; d++) r0[d] = rises[d];
        pulse(8'h30);
        pulse(8'h31);
        repeat (120) step();
        check("b2b_len", 0, 32'(last_run[0]), 32'd96);
        check("b2b_len", 1, 32'(last_run[1]), 32'd88);
        check("b2b_len", 2, 32'(last_run[2]), 32'd80);
        for (int d = 0; d < 3; d++) check("b2b_runs", d, 32'(rises[d] - r0[d]), 32'd1);

        // Six keys during a frame: the depth-4 instance drops the sixth
        for (int d = 0; d < 3; d++) r0[d] = rises[d];
        for (int i = 0; i < 6; i++) pulse(8'h61 + 8'(i));
        check("ovf_after_burst", 0, 32'(ovf_w[0]), 32'd1);
        check("drop_after_burst", 0, 32'(drop_w[0]), 32'd1);
        check("last_after_burst", 0, 32'(last_w[0]), 32'h65);
        check("count_after_burst", 0, 32'(cnt_w[0]), 32'd4);
        check("ovf_after_burst", 1, 32'(ovf_w[1]), 32'd0);
        check("last_after_burst", 1, 32'(last_w[1]), 32'h66);
        check("count_after_burst", 2, 32'(cnt_w[2]), 32'd5);
        repeat (300) step();
        check("burst_len", 0, 32'(last_run[0]), 32'd240);
        check("burst_len", 1, 32'(last_run[1]), 32'd264);
        check("burst_len", 2, 32'(last_run[2]), 32'd240);

        // Reset mid-frame with bytes queued and the key level held through reset
        for (int i = 0; i < 4; i++) pulse(8'h71 + 8'(i));
        repeat (6) step();
        rst = 0; in_valid = 1; in_data = 8'h7F;
        step();
        for (int d = 0; d < 3; d++) begin
            check("midreset_txd", d, 32'(txd_w[d]), 32'd1);
            check("midreset_busy", d, 32'(busy_w[d]), 32'd0);
            check("midreset_count", d, 32'(cnt_w[d]), 32'd0);
        end
        rst = 1;
        for (int d = 0; d < 3; d++) r0[d] = rises[d];
        repeat (60) step();
        for (int d = 0; d < 3; d++) check("no_frame_after_reset", d, 32'(rises[d] - r0[d]), 32'd0);
        in_valid = 0;
        repeat (2) step();

        // Random key traffic at varying densities
        for (int seg = 0; seg < 6; seg++) begin
            case ($urandom_range(0, 3))
                0: p = 5;
                1: p = 20;
                2: p = 50;
                default: p = 80;
            endcase
            repeat (500) begin
                in_valid = ($urandom_range(0, 99) < p);
                in_data  = 8'($urandom);
                step();
            end
        end

        // Hammer keystrokes to push every drop counter into saturation
        repeat (300) pulse(8'($urandom));
        for (int d = 0; d < 3; d++) begin
            check("drop_saturated", d, 32'(drop_w[d]), 32'hFF);
            check("ovf_sticky", d, 32'(ovf_w[d]), 32'd1);
        end
        in_valid = 0;
        repeat (800) step();
        for (int d = 0; d < 3; d++) begin
            check("drained_count", d, 32'(cnt_w[d]), 32'd0);
            check("drained_busy", d, 32'(busy_w[d]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
